// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single multi-cycle ALU.
// One operation in flight: accept in IDLE, compute in EXEC, hold response in RESP.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [2:0]         op_ctrl;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_id;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection, handshake and next-state; a tie goes to the requester not served last
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;

        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end

        if (state == IDLE && !reset) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
        end
        accept = req0_ready || req1_ready;

        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU on the captured operation; codes 100/101 are unsupported
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_ctrl)
            3'b000:  alu_res = op_a & op_b;
            3'b001:  alu_res = op_a | op_b;
            3'b010:  alu_res = op_a + op_b;
            3'b011:  alu_res = WIDTH'($signed(op_a) * $signed(op_b));
            3'b110:  alu_res = op_a - op_b;
            3'b111:  alu_res = WIDTH'($signed(op_a) <= $signed(op_b));
            default: alu_err = 1'b1;
        endcase
    end

    // Operand capture on accept, response registers loaded in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            op_ctrl    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                op_id      <= grant;
                op_ctrl    <= grant ? req1_ctrl : req0_ctrl;
                op_a       <= grant ? req1_a    : req0_a;
                op_b       <= grant ? req1_b    : req0_b;
            end
            if (state == EXEC) begin
                rsp_id     <= op_id;
                rsp_result <= alu_res;
                rsp_zero   <= (alu_res == '0);
                rsp_err    <= alu_err;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
